// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank driver: FSM states, request modes
// and the per-bit JK excitation used for word loads.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Returns {j, k} that moves a cell from q_cur to q_tgt without using J=K=1.
  function automatic logic [1:0] jk_excite(input logic q_cur, input logic q_tgt);
    return {~q_cur & q_tgt, q_cur & ~q_tgt};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle; sync active-high reset.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK cells to a requested word or toggles a mask, then
// verifies the result and keeps a saturating count of bits changed.
//
// state | meaning
// IDLE  | ready for a request, bank held
// APPLY | registered J/K presented to the bank
// CHECK | bank compared against the expected word, done issued next edge
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             tgt_mode,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int SW = CNT_W + 7;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] exp_q, j_q, k_q;
  logic [WIDTH-1:0] exp_nxt, j_nxt, k_nxt;
  logic [WIDTH-1:0] j_cell, k_cell;
  logic [WIDTH-1:0] diff;
  logic [1:0]       jk;
  logic [5:0]       pop;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hs;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tgt_ready = 1'b0;
    j_cell    = '0;
    k_cell    = '0;
    case (state)
      IDLE: begin
        tgt_ready = ~reset;
        if (tgt_valid && !reset) state_nxt = APPLY;
      end
      APPLY: begin
        j_cell    = j_q;
        k_cell    = k_q;
        state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hs = tgt_valid & tgt_ready;

  always_comb begin
    exp_nxt = (tgt_mode == MODE_TOGGLE) ? (q ^ tgt_data) : tgt_data;
    j_nxt   = '0;
    k_nxt   = '0;
    jk      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (tgt_mode == MODE_TOGGLE) jk = {tgt_data[i], tgt_data[i]};
      else                         jk = jk_excite(q[i], tgt_data[i]);
      j_nxt[i] = jk[1];
      k_nxt[i] = jk[0];
    end
  end

  // Bits that will change equals popcount of the J|K excitation, i.e. q ^ exp.
  always_comb begin
    diff = q ^ exp_nxt;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + 6'(diff[i]);
    sum     = SW'(toggle_cnt) + SW'(pop);
    cnt_nxt = (|sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      done <= (state == CHECK);
      if (state == CHECK) err <= (q != exp_q);
      if (hs) begin
        exp_q      <= exp_nxt;
        j_q        <= j_nxt;
        k_q        <= k_nxt;
        toggle_cnt <= cnt_nxt;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_cell[i]),
      .k     (k_cell[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench for jk_bank_driver: two instances (16-bit and 4-bit
// counters) share stimulus; expected results are queued at each handshake.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tgt_valid = 1'b0;
  logic       tgt_mode = 1'b0;
  logic [7:0] tgt_data = '0;
  logic       tgt_ready, done, err;
  logic [7:0] q;
  logic [15:0] toggle_cnt;
  logic       tgt_ready4, done4, err4;
  logic [7:0] q4;
  logic [3:0] toggle_cnt4;

  jk_bank_driver #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_mode(tgt_mode), .tgt_data(tgt_data), .q(q), .done(done), .err(err),
    .toggle_cnt(toggle_cnt)
  );

  jk_bank_driver #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready4),
    .tgt_mode(tgt_mode), .tgt_data(tgt_data), .q(q4), .done(done4), .err(err4),
    .toggle_cnt(toggle_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    int          hs;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  int          cyc      = 0;
  int          last_hs  = 0;
  logic [7:0]  m_q      = '0;
  logic [15:0] m_cnt    = '0;
  logic [3:0]  m_cnt4   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Called at a negedge where tgt_ready is seen: the next posedge is the handshake.
  task automatic push(input logic mode, input logic [7:0] data, input bit chk_gap);
    exp_t       e;
    logic [7:0] x;
    int         pc;
    x  = mode ? (m_q ^ data) : data;
    pc = $countones(m_q ^ x);
    m_q = x;
    m_cnt  = (32'(m_cnt) + pc > 65535) ? 16'hFFFF : 16'(32'(m_cnt) + pc);
    m_cnt4 = (32'(m_cnt4) + pc > 15) ? 4'hF : 4'(32'(m_cnt4) + pc);
    e.q = m_q; e.cnt = m_cnt; e.cnt4 = m_cnt4; e.hs = cyc + 1;
    if (chk_gap) check("ready_spacing", e.hs - last_hs, 3);
    last_hs = e.hs;
    sb.push_back(e);
  endtask

  task automatic send(input logic mode, input logic [7:0] data, input bit chk_gap);
    bit got = 1'b0;
    tgt_valid = 1'b1; tgt_mode = mode; tgt_data = data;
    for (int n = 0; n < 10 && !got; n++) begin
      if (tgt_ready) begin
        push(mode, data, chk_gap);
        got = 1'b1;
      end
      @(negedge clk);
    end
    if (!got) check("handshake_timeout", 0, 1);
  endtask

  task automatic drain();
    tgt_valid = 1'b0;
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) check("done_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("q", q, mon_e.q);
        check("err", err, 0);
        check("toggle_cnt", toggle_cnt, mon_e.cnt);
        check("toggle_cnt4", toggle_cnt4, mon_e.cnt4);
        check("latency", cyc - mon_e.hs, 2);
        check("done4", done4, 1);
        check("q4", q4, mon_e.q);
      end
    end
  end

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    check("rst_ready", tgt_ready, 0);
    check("rst_q", q, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", toggle_cnt, 0);
    reset = 1'b0;
    #1 check("ready_after_release", tgt_ready, 1);
    @(negedge clk);

    send(1'b0, 8'hA5, 1'b0); drain();
    check("load_a5_cnt", toggle_cnt, 4);
    send(1'b1, 8'hFF, 1'b0); drain();
    check("toggle_ff_q", q, 8'h5A);
    check("toggle_ff_cnt", toggle_cnt, 12);
    send(1'b0, 8'h5A, 1'b0); drain();
    check("same_q", q, 8'h5A);
    check("same_cnt", toggle_cnt, 12);

    d0 = n_done;
    send(1'b1, 8'h0F, 1'b0);
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'h3C, 1'b1);
    send(1'b1, 8'h81, 1'b1);
    drain();
    check("b2b_done_count", n_done - d0, 4);

    // Abort a 0xFF load by resetting in its APPLY cycle.
    d0 = n_done;
    tgt_valid = 1'b1; tgt_mode = 1'b0; tgt_data = 8'hFF;
    check("abort_ready", tgt_ready, 1);
    @(negedge clk);
    reset = 1'b1; tgt_valid = 1'b0;
    #1 check("ready_in_reset", tgt_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_q = '0; m_cnt = '0; m_cnt4 = '0;
    #1 check("abort_ready_release", tgt_ready, 1);
    @(negedge clk);
    check("abort_q", q, 0);
    check("abort_cnt", toggle_cnt, 0);
    check("abort_ready_next", tgt_ready, 1);
    repeat (3) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);

    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'hFF, 1'b0); drain();
    end
    check("sat_cnt4", toggle_cnt4, 15);
    check("sat_cnt16", toggle_cnt, 24);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of JK cells in the bank (legal range 1..32).
REQ-002 SHALL have parameter CNT_W, default 16, giving the toggle-counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tgt_valid  input  1  request present.
REQ-006 SHALL have port tgt_ready  output  1  driver can accept a request.
REQ-007 SHALL have port tgt_mode  input  1  request mode: 0 = load word, 1 = toggle mask.
REQ-008 SHALL have port tgt_data  input  WIDTH  target word (mode 0) or toggle mask (mode 1).
REQ-009 SHALL have port q  output  WIDTH  current JK bank state.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  mismatch flag, qualified by done.
REQ-012 SHALL have port toggle_cnt  output  CNT_W  saturating count of bits changed since reset.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, APPLY and CHECK.
REQ-014 SHALL drive tgt_ready high exactly when the state is IDLE.
REQ-015 SHALL treat a handshake (tgt_valid & tgt_ready at edge T) as follows: latch exp = tgt_data (mode 0) or q ^ tgt_data (mode 1), latch the J/K vectors, and move to APPLY.
REQ-016 SHALL compute the mode 0 excitation per bit as: q=0->0: J=0 K=0; q=0->1: J=1 K=0; q=1->0: J=0 K=1; q=1->1: J=0 K=0. J=K=1 is never used in mode 0.
REQ-017 SHALL compute the mode 1 excitation per bit as J=K=tgt_data[i] (toggle or hold).
REQ-018 SHALL hold the registered J/K vectors valid during APPLY, with the bank capturing them at edge T+1; in IDLE and CHECK, J=K=0 for every cell (hold).
REQ-019 SHALL, during CHECK, compare q with exp; at edge T+2 it registers done=1 and err=(q!=exp) and returns to IDLE.
REQ-020 SHALL hold done high for exactly one cycle, and hold err until the next done pulse or reset.
REQ-021 SHALL give a handshake-to-done latency of exactly 2 edges, and allow a new request to be accepted in the same cycle that done is high; maximum throughput is one request per 3 cycles.
REQ-022 SHALL, at edge T, add popcount(q ^ exp) to toggle_cnt, saturating at all-ones with no wrap.
REQ-023 SHALL ignore tgt_valid outside IDLE and leave tgt_data/tgt_mode unsampled; requests are not queued.
REQ-024 SHALL complete a request whose target equals q normally: J=K=0, popcount 0, done=1, err=0.
REQ-025 SHALL treat WIDTH=1 as legal, with identical behaviour.

Reset
REQ-026 SHALL, while reset is high at an edge, clear the state to IDLE, q to 0, J/K regs to 0, exp to 0, done to 0, err to 0 and toggle_cnt to 0.
REQ-027 SHALL treat reset asserted during APPLY or CHECK as aborting the request: no done pulse, and q is forced to 0 regardless of pending J/K.
REQ-028 SHALL take reset priority over the handshake, keeping tgt_ready low while reset is high and high on the first cycle after release.

Structure
REQ-029 SHALL place the FSM state enum, the mode encoding (MODE_LOAD=0, MODE_TOGGLE=1) and the J/K excitation function in the shared package jk_pkg.
REQ-030 SHALL instantiate WIDTH copies of sub-module jk_cell, each a single JK flip-flop with synchronous active-high reset, ports clk, reset, j, k, q, implementing 00 hold / 01 clear / 10 set / 11 toggle on the clock edge only.
REQ-031 SHALL keep the FSM, excitation registers, compare logic and counter in jk_bank_driver; the bank q SHALL be output directly.

Verification
REQ-032 SHALL verify: after reset, with WIDTH=8, a mode 0 request with data 0xA5 gives q=0xA5 two edges later, done=1, err=0, and toggle_cnt=4.
REQ-033 SHALL verify: from q=0xA5, a mode 1 request with mask 0xFF gives q=0x5A, err=0, and toggle_cnt=12.
REQ-034 SHALL verify: a mode 0 request equal to the current q (0x5A) leaves q unchanged, with done=1, err=0, and toggle_cnt unchanged.
REQ-035 SHALL verify: tgt_valid held high continuously for 4 requests gives ready pulses every 3 cycles and 4 done pulses, with no request lost or duplicated.
REQ-036 SHALL verify: reset asserted in the APPLY cycle of a 0xFF load gives q=0, no done pulse, toggle_cnt=0, and ready=1 the cycle after release.
REQ-037 SHALL verify: with CNT_W=4, repeated 0xFF toggles saturate toggle_cnt at 15 without wrapping.
